// File: rtl/router_sync_n.sv
// rtl/router_sync_n.sv - N-channel router synchroniser: address latch, one-hot write enable, full mux, valid, timeout soft reset.
// Optional sticky timeout status under ROUTER_SYNC_STICKY_STATUS_EN.
module router_sync_n #(
    parameter int NUM_CH  = 3,
    parameter int ADDR_W  = $clog2(NUM_CH),
    parameter int TIMEOUT = 30,
    parameter int CNT_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              detect_addr,
    input  logic [ADDR_W-1:0] datain,
    input  logic              we_reg,
    input  logic [NUM_CH-1:0] re,
    input  logic [NUM_CH-1:0] empty,
    input  logic [NUM_CH-1:0] full,
`ifdef ROUTER_SYNC_STICKY_STATUS_EN
    input  logic              sts_clr,
    output logic [NUM_CH-1:0] timeout_sts,
`endif
    output logic [NUM_CH-1:0] we,
    output logic [NUM_CH-1:0] vld_out,
    output logic [NUM_CH-1:0] soft_reset,
    output logic              fifo_full,
    output logic              addr_err
);

    localparam logic [CNT_W-1:0]  LP_TMAX   = CNT_W'(TIMEOUT - 1);
    localparam logic [ADDR_W:0]   LP_NUM_CH = (ADDR_W + 1)'(NUM_CH);

    if (TIMEOUT == 0 || TIMEOUT >= (2 ** CNT_W)) begin : g_timeout_range_err
        $error("router_sync_n: TIMEOUT must be in 1..2**CNT_W-1");
    end
    if (NUM_CH < 2 || NUM_CH > 16) begin : g_num_ch_range_err
        $error("router_sync_n: NUM_CH must be in 2..16");
    end

    logic [ADDR_W-1:0] r_fifo_addr;
    logic [CNT_W-1:0]  r_cnt [NUM_CH];
    logic [NUM_CH-1:0] r_soft_reset;
    logic [NUM_CH-1:0] w_stall;
    logic [NUM_CH-1:0] w_hit;
    logic              w_addr_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fifo_addr <= '0;
        end else if (detect_addr) begin
            r_fifo_addr <= datain;
        end
    end

    assign w_addr_err = ({1'b0, r_fifo_addr} >= LP_NUM_CH);
    assign addr_err   = w_addr_err;
    assign vld_out    = ~empty;

    // Decode by compare rather than shift/index so an out-of-range address selects nothing.
    always_comb begin
        we        = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!w_addr_err && r_fifo_addr == ADDR_W'(i)) begin
                we[i]     = we_reg;
                fifo_full = full[i];
            end
        end
    end

    always_comb begin
        w_stall = '0;
        w_hit   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_stall[i] = vld_out[i] && !re[i];
            w_hit[i]   = w_stall[i] && (r_cnt[i] == LP_TMAX);
        end
    end

    // The pulse cycle also restarts the window, so a persisting stall repeats every TIMEOUT cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_soft_reset <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_soft_reset <= w_hit;
            for (int i = 0; i < NUM_CH; i++) begin
                if (!w_stall[i] || w_hit[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign soft_reset = r_soft_reset;

`ifdef ROUTER_SYNC_STICKY_STATUS_EN
    logic [NUM_CH-1:0] r_timeout_sts;

    // Set has priority over clear so a timeout coinciding with sts_clr is not lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_timeout_sts <= '0;
        end else begin
            r_timeout_sts <= (r_timeout_sts & ~{NUM_CH{sts_clr}}) | w_hit;
        end
    end

    assign timeout_sts = r_timeout_sts;
`endif

endmodule

// File: tb/tb_router_sync_n.sv
// tb/tb_router_sync_n.sv - directed self-checking bench for router_sync_n (NUM_CH=3, TIMEOUT=30).
module tb_router_sync_n;

    logic       clk;
    logic       reset;
    logic       detect_addr;
    logic [1:0] datain;
    logic       we_reg;
    logic [2:0] re;
    logic [2:0] empty;
    logic [2:0] full;
    logic [2:0] we;
    logic [2:0] vld_out;
    logic [2:0] soft_reset;
    logic       fifo_full;
    logic       addr_err;
`ifdef ROUTER_SYNC_STICKY_STATUS_EN
    logic       sts_clr;
    logic [2:0] timeout_sts;
`endif

    int n_total;
    int n_bad;

    router_sync_n #(
        .NUM_CH (3),
        .TIMEOUT(30),
        .CNT_W  (5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .detect_addr(detect_addr),
        .datain     (datain),
        .we_reg     (we_reg),
        .re         (re),
        .empty      (empty),
        .full       (full),
`ifdef ROUTER_SYNC_STICKY_STATUS_EN
        .sts_clr    (sts_clr),
        .timeout_sts(timeout_sts),
`endif
        .we         (we),
        .vld_out    (vld_out),
        .soft_reset (soft_reset),
        .fifo_full  (fifo_full),
        .addr_err   (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_total     = 0;
        n_bad       = 0;
        reset       = 1'b1;
        detect_addr = 1'b0;
        datain      = 2'd0;
        we_reg      = 1'b0;
        re          = 3'b000;
        empty       = 3'b111;
        full        = 3'b001;
`ifdef ROUTER_SYNC_STICKY_STATUS_EN
        sts_clr     = 1'b0;
`endif
        step();
        step();
        #1;
        chk("rst_soft_reset", 32'(soft_reset), 32'h0);
        chk("rst_we_idle", 32'(we), 32'h0);
        chk("rst_addr_err", 32'(addr_err), 32'h0);
        chk("rst_fifo_full_ch0", 32'(fifo_full), 32'h1);
        we_reg = 1'b1;
        #1;
        chk("rst_we_ch0", 32'(we), 32'h1);

        reset       = 1'b0;
        we_reg      = 1'b0;
        detect_addr = 1'b1;
        datain      = 2'b10;
        full        = 3'b100;
        #1;
        chk("latch_latency_full", 32'(fifo_full), 32'h0);
        step();
        detect_addr = 1'b0;
        we_reg      = 1'b1;
        #1;
        chk("we_ch2", 32'(we), 32'h4);
        chk("fifo_full_ch2", 32'(fifo_full), 32'h1);
        chk("addr_err_ch2", 32'(addr_err), 32'h0);

        detect_addr = 1'b1;
        datain      = 2'b01;
        #1;
        chk("we_old_addr", 32'(we), 32'h4);
        step();
        detect_addr = 1'b0;
        #1;
        chk("we_ch1", 32'(we), 32'h2);
        chk("fifo_full_ch1", 32'(fifo_full), 32'h0);

        detect_addr = 1'b1;
        datain      = 2'b11;
        step();
        detect_addr = 1'b0;
        full        = 3'b111;
        #1;
        chk("we_bad_addr", 32'(we), 32'h0);
        chk("addr_err_bad", 32'(addr_err), 32'h1);
        chk("fifo_full_bad", 32'(fifo_full), 32'h0);
        we_reg      = 1'b0;
        detect_addr = 1'b1;
        datain      = 2'b00;
        step();
        detect_addr = 1'b0;
        full        = 3'b000;

        empty = 3'b101;
        #1;
        chk("vld_out_101", 32'(vld_out), 32'h2);
        empty = 3'b010;
        #1;
        chk("vld_out_010", 32'(vld_out), 32'h5);
        empty = 3'b111;
        step();

        // Persistent stall on ch1: pulses after the 30th and 60th stall edges.
        empty = 3'b101;
        for (int n = 1; n <= 61; n++) begin
            step();
            chk($sformatf("stall_n%0d", n), 32'(soft_reset), (n == 30 || n == 60) ? 32'h2 : 32'h0);
        end
        empty = 3'b111;
        step();
        step();

        // re[1] on cycle 20 restarts the window; ch2 has data but is being read.
        empty = 3'b001;
        re    = 3'b100;
        for (int n = 1; n <= 52; n++) begin
            re[1] = (n == 20);
            step();
            chk($sformatf("re_pulse_n%0d", n), 32'(soft_reset), (n == 50) ? 32'h2 : 32'h0);
        end
        re    = 3'b000;
        empty = 3'b111;
        step();
        step();

        // Reset after 25 stall edges: a fresh 30 edges are required.
        empty = 3'b101;
        for (int n = 1; n <= 25; n++) begin
            step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_reset_sr", 32'(soft_reset), 32'h0);
        for (int n = 1; n <= 31; n++) begin
            step();
            chk($sformatf("post_rst_n%0d", n), 32'(soft_reset), (n == 30) ? 32'h2 : 32'h0);
        end
        empty = 3'b111;
        step();

`ifdef ROUTER_SYNC_STICKY_STATUS_EN
        empty = 3'b110;
        for (int n = 1; n <= 30; n++) begin
            step();
        end
        chk("sts_set_sr", 32'(soft_reset), 32'h1);
        chk("sts_set", 32'(timeout_sts), 32'h1);
        empty = 3'b111;
        step();
        step();
        chk("sts_hold", 32'(timeout_sts), 32'h1);
        sts_clr = 1'b1;
        step();
        chk("sts_cleared", 32'(timeout_sts), 32'h0);
        empty = 3'b110;
        for (int n = 1; n <= 30; n++) begin
            step();
            chk($sformatf("sts_coinc_n%0d", n), 32'(timeout_sts), (n == 30) ? 32'h1 : 32'h0);
        end
        sts_clr = 1'b0;
        empty   = 3'b111;
        step();
        chk("sts_after_coinc", 32'(timeout_sts), 32'h1);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/router_sync_n.md
Name: router_sync_n

Overview:
- Parametrised N-channel router synchroniser.
- Captures the destination address from the header and generates the one-hot write enable into the selected output FIFO.
- Muxes back that FIFO's full flag, drives per-channel valid from the FIFO empty flags, and issues a per-channel soft reset when a channel holds data unread for TIMEOUT consecutive cycles.
- Sits between the router FSM/register block and the N output FIFOs. Adds address-range checking and a deterministic idle state.

Parameters:
- NUM_CH, 3, number of output channels/FIFOs (2..16).
- ADDR_W, $clog2(NUM_CH), width of the destination address field.
- TIMEOUT, 30, consecutive unread-valid cycles before soft reset (1..2^CNT_W-1).
- CNT_W, 5, width of each per-channel timeout counter.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- detect_addr  in  1  header present; latch datain this cycle.
- datain  in  ADDR_W  destination address field of the header.
- we_reg  in  1  FSM write request for the current packet byte.
- re  in  NUM_CH  per-channel FIFO read enable.
- empty  in  NUM_CH  per-channel FIFO empty flag.
- full  in  NUM_CH  per-channel FIFO full flag.
- we  out  NUM_CH  one-hot FIFO write enable.
- vld_out  out  NUM_CH  per-channel data valid.
- soft_reset  out  NUM_CH  per-channel one-cycle soft-reset pulse (registered).
- fifo_full  out  1  full flag of the addressed FIFO.
- addr_err  out  1  latched address is >= NUM_CH.

Behaviour:
- Reset (reset=1 at a clk edge):
  - fifo_addr=0; all counters=0; soft_reset=0.
  - Combinational outputs then follow from fifo_addr=0: we=0 unless we_reg, fifo_full=full[0], addr_err=0.
- Address latch:
  - When detect_addr=1, fifo_addr<=datain at the clk edge.
  - The new address is visible to we, fifo_full and addr_err from the next cycle; detect_addr has 1-cycle latency.
  - Otherwise fifo_addr holds.
- addr_err = (fifo_addr >= NUM_CH). This is combinational from the register.
- we (combinational, no latch):
  - we = (we_reg && !addr_err) ? (1 << fifo_addr) : 0.
  - we is never multi-hot.
  - Writes to an invalid address are dropped.
- fifo_full (combinational) = addr_err ? 0 : full[fifo_addr]. An invalid address never stalls the FSM.
- vld_out[i] = !empty[i], purely combinational.
- Timeout, per channel i, independent of all other channels:
  - stall_i = vld_out[i] && !re[i].
  - If !stall_i, cnt_i<=0 and soft_reset[i]<=0.
  - If stall_i and cnt_i < TIMEOUT-1, cnt_i<=cnt_i+1 and soft_reset[i]<=0.
  - If stall_i and cnt_i == TIMEOUT-1, soft_reset[i]<=1 and cnt_i<=0.
  - Result: soft_reset[i] is high for exactly one cycle, in the cycle after the TIMEOUT-th consecutive stall cycle.
  - If the stall persists after the pulse, counting restarts from 0 and the next pulse follows TIMEOUT cycles later.
- re[i]=1 while empty[i]=1 is not a stall; the counter clears.
- A single re[i] pulse anywhere in the window clears cnt_i. The window restarts on the following cycle.
- Simultaneous detect_addr and we_reg: we uses the old fifo_addr in that cycle.
- Reset mid-count: counters and soft_reset clear on the reset edge. No pulse is emitted in the cycle following the reset edge.
- Counter arithmetic is unsigned, CNT_W bits, and never wraps, because TIMEOUT-1 < 2^CNT_W. An elaboration check fails if TIMEOUT >= 2^CNT_W or TIMEOUT == 0.

Optional Feature:
- Macro: ROUTER_SYNC_STICKY_STATUS_EN.
- Defined:
  - Adds input sts_clr (1 bit) and output timeout_sts (NUM_CH bits).
  - timeout_sts[i] sets at the same clk edge that sets soft_reset[i] high, i.e. it rises together with the soft_reset[i] pulse, and stays set.
  - It clears on reset or sts_clr=1. If set and clear coincide, set wins.
- Not defined: the ports are absent and there is no extra logic.

Test Plan:
- NUM_CH=3: reset, then detect_addr=1 with datain=2'b10, then we_reg=1 on the next cycle -> we=3'b100; full=3'b100 -> fifo_full=1.
- datain=2'b11 latched, we_reg=1 -> we=3'b000, addr_err=1, fifo_full=0 even with full=3'b111.
- empty[1]=0, re[1]=0 held 30 cycles from cnt=0 -> soft_reset[1]=1 for exactly one cycle, on cycle 31. With the stall held a further 30 cycles, a second pulse follows.
- Same stall with re[1]=1 pulsed on cycle 20 -> no pulse until 30 stall cycles after cycle 20. Channels 0 and 2 remain unaffected.
- reset asserted at stall cycle 25 -> cnt and soft_reset clear; after release, a full 30 new stall cycles are needed before a pulse.
- ROUTER_SYNC_STICKY_STATUS_EN with a channel-0 timeout -> timeout_sts=3'b001 and it holds; sts_clr=1 -> 3'b000; sts_clr coincident with a new timeout -> stays set.
